// File: rtl/zbus_arbiter_if.sv
// Bus-ownership interface between the requesters and the zbus arbiter.
interface zbus_arbiter_if #(
   parameter int NREQ    = 4,
   parameter int IDXSIZE = 2
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    bus_en;
   logic               bus_busy;
   logic [IDXSIZE-1:0] owner;
   logic               turn;

   // Requester side
   modport master (output req, input gnt, bus_en, bus_busy, owner, turn);
   // Arbiter side
   modport slave  (input req, output gnt, bus_en, bus_busy, owner, turn);
endinterface

// File: rtl/zbus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus. Produces one-hot
// zbuffer enables, inserts TURNCYC all-Z cycles between owners and can
// preempt an owner after MAXHOLD cycles when others are waiting.
module zbus_arbiter #(
   parameter int NREQ    = 4,
   parameter int TURNCYC = 1,
   parameter int MAXHOLD = 0,
   parameter int IDXSIZE = 2
) (
   input  logic          clk,
   input  logic          rst,
   zbus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam logic [IDXSIZE:0] NREQ_W    = (IDXSIZE+1)'(NREQ);
   localparam logic [7:0]       HOLD_LIM  = (MAXHOLD > 0) ? 8'(MAXHOLD - 1) : 8'd0;
   localparam logic [3:0]       TURN_INIT = 4'(TURNCYC - 1);

   state_t             state;
   logic [NREQ-1:0]    gnt_q;
   logic [IDXSIZE-1:0] owner_q;
   logic               turn_q;
   logic [IDXSIZE-1:0] ptr;
   logic [7:0]         hold_cnt;
   logic [3:0]         turn_cnt;

   logic [2*NREQ-1:0]  req_dbl;
   logic [NREQ-1:0]    req_rot;
   logic [IDXSIZE:0]   win_sum;
   logic [IDXSIZE:0]   win_inc;
   logic               win_vld;
   logic [IDXSIZE-1:0] win_idx;
   logic [IDXSIZE-1:0] win_nxt;
   logic [NREQ-1:0]    win_oh;
   logic               own_req;
   logic               others;
   logic               preempt;

   // Rotate requests so that ptr lands on bit 0, then take the first set bit
   always_comb begin
      req_dbl = {bus.req, bus.req};
      req_rot = req_dbl[NREQ-1:0];
      req_rot = NREQ'(req_dbl >> ptr);
      win_vld = 1'b0;
      win_sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_vld && req_rot[k]) begin
            win_vld = 1'b1;
            win_sum = {1'b0, ptr} + (IDXSIZE+1)'(k);
         end
      end
      win_idx = (win_sum >= NREQ_W) ? IDXSIZE'(win_sum - NREQ_W) : win_sum[IDXSIZE-1:0];
      win_inc = {1'b0, win_idx} + 1'b1;
      win_nxt = (win_inc == NREQ_W) ? '0 : win_inc[IDXSIZE-1:0];
      win_oh  = NREQ'(1) << win_idx;
   end

   // gnt_q is one-hot on the owner while granted, so masking by it isolates
   // the owner's request from everyone else's
   assign own_req = |(bus.req & gnt_q);
   assign others  = |(bus.req & ~gnt_q);
   // hold_cnt saturates, so >= keeps preemption armed if others arrive late
   assign preempt = (MAXHOLD != 0) && (hold_cnt >= HOLD_LIM) && others;

   // Ownership state machine with registered grant/turn/owner outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         turn_q   <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state    <= GRANT;
                  gnt_q    <= win_oh;
                  owner_q  <= win_idx;
                  ptr      <= win_nxt;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               // Release takes priority; both paths go through turnaround
               if (!own_req || preempt) begin
                  state    <= TURN;
                  gnt_q    <= '0;
                  turn_q   <= 1'b1;
                  turn_cnt <= TURN_INIT;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            TURN: begin
               if (turn_cnt != 4'd0) begin
                  turn_cnt <= turn_cnt - 4'd1;
               end else if (win_vld) begin
                  state    <= GRANT;
                  gnt_q    <= win_oh;
                  owner_q  <= win_idx;
                  ptr      <= win_nxt;
                  hold_cnt <= '0;
                  turn_q   <= 1'b0;
               end else begin
                  state  <= IDLE;
                  turn_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               gnt_q  <= '0;
               turn_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.bus_en   = gnt_q;
   assign bus.bus_busy = |gnt_q;
   assign bus.owner    = owner_q;
   assign bus.turn     = turn_q;

endmodule

// File: tb/tb_zbus_arbiter.sv
// Bench for zbus_arbiter: three instances cover TURNCYC=1/MAXHOLD=0 (a),
// TURNCYC=3 (b) and MAXHOLD=4 (c). Rows of a vector table are applied one
// clock each; the expected result is queued on drive and popped on sample.
module tb_zbus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   zbus_arbiter_if #(.NREQ(4), .IDXSIZE(2)) ia ();
   zbus_arbiter_if #(.NREQ(4), .IDXSIZE(2)) ib ();
   zbus_arbiter_if #(.NREQ(4), .IDXSIZE(2)) ic ();

   zbus_arbiter #(.NREQ(4), .TURNCYC(1), .MAXHOLD(0), .IDXSIZE(2))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   zbus_arbiter #(.NREQ(4), .TURNCYC(3), .MAXHOLD(0), .IDXSIZE(2))
      dut_b (.clk(clk), .rst(rst), .bus(ib));
   zbus_arbiter #(.NREQ(4), .TURNCYC(1), .MAXHOLD(4), .IDXSIZE(2))
      dut_c (.clk(clk), .rst(rst), .bus(ic));

   typedef struct {
      int         sel;
      bit         rst_first;
      logic [3:0] req;
      logic [3:0] gnt;
      logic       turn;
      logic [1:0] owner;
   } vec_t;

   typedef struct {
      int         sel;
      logic [3:0] gnt;
      logic       turn;
      logic [1:0] owner;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input int sel, input bit r, input logic [3:0] rq,
                      input logic [3:0] g, input logic t, input logic [1:0] o);
      vec_t v;
      v.sel = sel; v.rst_first = r; v.req = rq; v.gnt = g; v.turn = t; v.owner = o;
      vecs.push_back(v);
   endtask

   task automatic sample(input int sel, output logic [3:0] g, output logic [3:0] en,
                         output logic busy, output logic t, output logic [1:0] o);
      case (sel)
         0: begin g = ia.gnt; en = ia.bus_en; busy = ia.bus_busy; t = ia.turn; o = ia.owner; end
         1: begin g = ib.gnt; en = ib.bus_en; busy = ib.bus_busy; t = ib.turn; o = ib.owner; end
         default: begin g = ic.gnt; en = ic.bus_en; busy = ic.bus_busy; t = ic.turn; o = ic.owner; end
      endcase
   endtask

   task automatic chk_outputs(input string tag, input int sel, input logic [3:0] g_e,
                              input logic t_e, input logic [1:0] o_e);
      logic [3:0] g, en;
      logic busy, t;
      logic [1:0] o;
      sample(sel, g, en, busy, t, o);
      chk({tag, " gnt"},   {4'b0, g},    {4'b0, g_e});
      chk({tag, " bus_en"}, {4'b0, en},  {4'b0, g_e});
      chk({tag, " turn"},  {7'b0, t},    {7'b0, t_e});
      chk({tag, " owner"}, {6'b0, o},    {6'b0, o_e});
      chk({tag, " busy"},  {7'b0, busy}, {7'b0, (g_e != 4'b0)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ia.req = '0; ib.req = '0; ic.req = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) chk_outputs($sformatf("reset dut%0d", s), s, 4'b0, 1'b0, 2'd0);
   endtask

   // Structural invariants on every instance, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 3; s++) begin
            logic [3:0] g, en;
            logic busy, t;
            logic [1:0] o;
            sample(s, g, en, busy, t, o);
            chk($sformatf("inv%0d onehot", s), {7'b0, ($countones(en) > 1)}, 8'd0);
            chk($sformatf("inv%0d en_eq_gnt", s), {4'b0, en}, {4'b0, g});
            chk($sformatf("inv%0d busy", s), {7'b0, busy}, {7'b0, |g});
            chk($sformatf("inv%0d turn_busy", s), {7'b0, (t & busy)}, 8'd0);
         end
      end
   end

   initial begin
      exp_t e;
      ia.req = '0; ib.req = '0; ic.req = '0;

      // Single requester on a: 3 grant cycles, one turnaround, idle
      add(0, 1, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0);
      add(0, 0, 4'b0000, 4'b0000, 0, 0);
      // Round robin on a: 0,1,2,3,0 with 2-cycle ownerships
      add(0, 1, 4'b1111, 4'b0001, 0, 0);
      add(0, 0, 4'b1111, 4'b0001, 0, 0);
      add(0, 0, 4'b1110, 4'b0000, 1, 0);
      add(0, 0, 4'b1111, 4'b0010, 0, 1);
      add(0, 0, 4'b1111, 4'b0010, 0, 1);
      add(0, 0, 4'b1101, 4'b0000, 1, 1);
      add(0, 0, 4'b1111, 4'b0100, 0, 2);
      add(0, 0, 4'b1111, 4'b0100, 0, 2);
      add(0, 0, 4'b1011, 4'b0000, 1, 2);
      add(0, 0, 4'b1111, 4'b1000, 0, 3);
      add(0, 0, 4'b1111, 4'b1000, 0, 3);
      add(0, 0, 4'b0111, 4'b0000, 1, 3);
      add(0, 0, 4'b1111, 4'b0001, 0, 0);
      add(0, 0, 4'b1111, 4'b0001, 0, 0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0);
      add(0, 0, 4'b0000, 4'b0000, 0, 0);
      // Same-owner re-grant on a: one turnaround cycle even for the same owner
      add(0, 0, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0);
      add(0, 0, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0001, 4'b0001, 0, 0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0);
      add(0, 0, 4'b0000, 4'b0000, 0, 0);
      // No preemption on a with MAXHOLD=0
      add(0, 1, 4'b0011, 4'b0001, 0, 0);
      for (int i = 0; i < 7; i++) add(0, 0, 4'b0011, 4'b0001, 0, 0);
      // Turnaround of 3 on b while req2 pends
      add(1, 1, 4'b0101, 4'b0001, 0, 0);
      add(1, 0, 4'b0101, 4'b0001, 0, 0);
      add(1, 0, 4'b0100, 4'b0000, 1, 0);
      add(1, 0, 4'b0100, 4'b0000, 1, 0);
      add(1, 0, 4'b0100, 4'b0000, 1, 0);
      add(1, 0, 4'b0100, 4'b0100, 0, 2);
      add(1, 0, 4'b0000, 4'b0000, 1, 2);
      // Preemption on c: 4 cycles each, one turnaround between
      add(2, 1, 4'b0011, 4'b0001, 0, 0);
      for (int i = 0; i < 3; i++) add(2, 0, 4'b0011, 4'b0001, 0, 0);
      add(2, 0, 4'b0011, 4'b0000, 1, 0);
      for (int i = 0; i < 4; i++) add(2, 0, 4'b0011, 4'b0010, 0, 1);
      add(2, 0, 4'b0011, 4'b0000, 1, 1);
      add(2, 0, 4'b0011, 4'b0001, 0, 0);
      add(2, 0, 4'b0000, 4'b0000, 1, 0);
      add(2, 0, 4'b0000, 4'b0000, 0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         @(negedge clk);
         ia.req = (vecs[i].sel == 0) ? vecs[i].req : 4'b0;
         ib.req = (vecs[i].sel == 1) ? vecs[i].req : 4'b0;
         ic.req = (vecs[i].sel == 2) ? vecs[i].req : 4'b0;
         e.sel = vecs[i].sel; e.gnt = vecs[i].gnt; e.turn = vecs[i].turn; e.owner = vecs[i].owner;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk_outputs($sformatf("vec%0d", i), e.sel, e.gnt, e.turn, e.owner);
      end

      // Asynchronous reset in the middle of a grant to requester 1
      do_reset();
      @(negedge clk);
      ia.req = 4'b0010;
      @(posedge clk);
      #1;
      chk_outputs("pre-reset grant", 0, 4'b0010, 1'b0, 2'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_outputs("async reset", 0, 4'b0000, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      ia.req = 4'b0100;
      @(posedge clk);
      #1;
      chk_outputs("post-reset grant", 0, 4'b0100, 1'b0, 2'd2);

      @(negedge clk);
      ia.req = '0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
